// File: rtl/bird_physics.sv
// Per-frame bird motion: gravity, flap impulse, terminal velocity, ceiling/floor limits, IDLE/FLY/DEAD.
// State updates on the dclk edge ending the first vsync-low cycle; flaps are latched until that tick, no backpressure.
module bird_physics #(
    parameter int Y_START      = 240,
    parameter int Y_MAX        = 465,
    parameter int GRAVITY      = 1,
    parameter int FLAP_IMPULSE = 8,
    parameter int V_MAX        = 10
) (
    input  logic       dclk,
    input  logic       clr,
    input  logic       vsync,
    input  logic       flap,
    output logic [9:0] y,
    output logic       game_over,
    output logic       playing
);

    typedef enum logic [1:0] {IDLE, FLY, DEAD} state_t;

    localparam logic        [9:0]  Y_START_V = 10'(Y_START);
    localparam logic        [9:0]  Y_MAX_V   = 10'(Y_MAX);
    localparam logic signed [10:0] Y_MAX_S   = 11'(Y_MAX);
    localparam logic signed [7:0]  V_FLAP    = 8'(-FLAP_IMPULSE);
    localparam logic signed [7:0]  V_CAP     = 8'(V_MAX);
    localparam logic signed [8:0]  V_CAP_W   = 9'(V_MAX);
    localparam logic signed [8:0]  GRAV_W    = 9'(GRAVITY);

    state_t             state, state_nxt;
    logic signed [7:0]  v, v_nxt, v_new, fly_v;
    logic signed [8:0]  v_grav;
    logic signed [10:0] y_sum;
    logic [9:0]         y_nxt, fly_y;
    logic               fly_dead;
    logic               flap_s1, flap_s2, flap_d, vsync_d, pend;
    logic               fedge, tick, flap_now;

    assign fedge    = flap_s2 & ~flap_d;
    assign tick     = vsync_d & ~vsync;
    assign flap_now = pend | fedge;

    // Pending flap is dropped on every tick so stale presses never carry into the next frame.
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            flap_s1 <= 1'b0;
            flap_s2 <= 1'b0;
            flap_d  <= 1'b0;
            vsync_d <= 1'b1;
            pend    <= 1'b0;
        end else begin
            flap_s1 <= flap;
            flap_s2 <= flap_s1;
            flap_d  <= flap_s2;
            vsync_d <= vsync;
            if (tick)
                pend <= 1'b0;
            else if (fedge)
                pend <= 1'b1;
        end
    end

    always_comb begin
        v_grav = $signed({v[7], v}) + GRAV_W;
        if (flap_now)
            v_new = V_FLAP;
        else if (v_grav > V_CAP_W)
            v_new = V_CAP;
        else
            v_new = v_grav[7:0];
        y_sum = $signed({1'b0, y}) + $signed({{3{v_new[7]}}, v_new});

        fly_y    = y_sum[9:0];
        fly_v    = v_new;
        fly_dead = 1'b0;
        if (y_sum[10]) begin
            fly_y = 10'd0;
            fly_v = 8'sd0;
        end else if (y_sum >= Y_MAX_S) begin
            fly_y    = Y_MAX_V;
            fly_v    = 8'sd0;
            fly_dead = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        y_nxt     = y;
        v_nxt     = v;
        case (state)
            IDLE: begin
                y_nxt = Y_START_V;
                v_nxt = 8'sd0;
                if (flap_now) begin
                    state_nxt = fly_dead ? DEAD : FLY;
                    y_nxt     = fly_y;
                    v_nxt     = fly_v;
                end
            end
            FLY: begin
                y_nxt = fly_y;
                v_nxt = fly_v;
                if (fly_dead)
                    state_nxt = DEAD;
            end
            DEAD: begin
                if (flap_now) begin
                    state_nxt = IDLE;
                    y_nxt     = Y_START_V;
                    v_nxt     = 8'sd0;
                end
            end
            default: begin
                state_nxt = IDLE;
                y_nxt     = Y_START_V;
                v_nxt     = 8'sd0;
            end
        endcase
    end

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            y         <= Y_START_V;
            v         <= 8'sd0;
            game_over <= 1'b0;
            playing   <= 1'b0;
        end else if (tick) begin
            state     <= state_nxt;
            y         <= y_nxt;
            v         <= v_nxt;
            game_over <= (state_nxt == DEAD);
            playing   <= (state_nxt == FLY);
        end
    end

endmodule
